decode_writeback: RTL and testbench



---
 rtl/decode_writeback_pkg.sv | 27 ++
 rtl/decode_writeback_regfile.sv | 44 ++++
 rtl/decode_writeback.sv | 126 ++++++++++++
 tb/tb_decode_writeback.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/decode_writeback_pkg.sv
// Shared constants for the Y86-64 decode/write-back stage: register ids,
// instruction codes and datapath sizing.
package decode_writeback_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned NUM_REGS = 15;
  localparam int unsigned CNT_W    = 32;

  localparam logic [DATA_W-1:0] STACK_INIT = 64'h0000_0000_0000_0200;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

endpackage

// File: rtl/decode_writeback_regfile.sv
// 15 x 64-bit register file with two read ports, a debug read port and two
// write ports; the M port overrides the E port on a same-id collision.
module regfile_2r2w
  import decode_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_e,
  input  logic [3:0]        addr_e,
  input  logic [DATA_W-1:0] data_e,
  input  logic              we_m,
  input  logic [3:0]        addr_m,
  input  logic [DATA_W-1:0] data_m,
  input  logic [3:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [3:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_r [NUM_REGS];

  // Id F is "no register" and reads as zero; reads show pre-edge state.
  assign rdata_a  = (raddr_a  == RNONE) ? {DATA_W{1'b0}} : regs_r[raddr_a];
  assign rdata_b  = (raddr_b  == RNONE) ? {DATA_W{1'b0}} : regs_r[raddr_b];
  assign dbg_data = (dbg_addr == RNONE) ? {DATA_W{1'b0}} : regs_r[dbg_addr];

  // Register update: reset loads %rsp with the stack base, M beats E.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (!rst_n) begin
        regs_r[i] <= (4'(i) == RRSP) ? STACK_INIT : {DATA_W{1'b0}};
      end else if (we_m && (addr_m == 4'(i))) begin
        regs_r[i] <= data_m;
      end else if (we_e && (addr_e == 4'(i))) begin
        regs_r[i] <= data_e;
      end else begin
        regs_r[i] <= regs_r[i];
      end
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode and write-back stage: source/destination selection from the
// fetched fields, register file access and a count of register-writing commits.
module decode_writeback
  import decode_writeback_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [3:0]        icode_i,
  input  logic [3:0]        ra_i,
  input  logic [3:0]        rb_i,
  input  logic              cnd_i,
  input  logic [DATA_W-1:0] vale_i,
  input  logic [DATA_W-1:0] valm_i,
  input  logic              wb_en_i,
  output logic [3:0]        srca_o,
  output logic [3:0]        srcb_o,
  output logic [3:0]        dste_o,
  output logic [3:0]        dstm_o,
  output logic [DATA_W-1:0] vala_o,
  output logic [DATA_W-1:0] valb_o,
  input  logic [3:0]        dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o,
  output logic [CNT_W-1:0]  wb_cnt_o
);

  logic [3:0]       srca_s, srcb_s, dste_s, dstm_s;
  logic             we_e_s, we_m_s;
  logic [CNT_W-1:0] wb_cnt_r;

  // Source and destination selection from the instruction code.
  always_comb begin
    srca_s = RNONE;
    srcb_s = RNONE;
    dste_s = RNONE;
    dstm_s = RNONE;
    case (icode_i)
      RRMOVQ: begin
        srca_s = ra_i;
        // Conditional move only commits when execute says the condition holds.
        if (cnd_i) begin
          dste_s = rb_i;
        end else begin
          dste_s = RNONE;
        end
      end
      IRMOVQ: dste_s = rb_i;
      RMMOVQ: begin
        srca_s = ra_i;
        srcb_s = rb_i;
      end
      MRMOVQ: begin
        srcb_s = rb_i;
        dstm_s = ra_i;
      end
      OPQ: begin
        srca_s = ra_i;
        srcb_s = rb_i;
        dste_s = rb_i;
      end
      CALL: begin
        srcb_s = RRSP;
        dste_s = RRSP;
      end
      RET: begin
        srca_s = RRSP;
        srcb_s = RRSP;
        dste_s = RRSP;
      end
      PUSHQ: begin
        srca_s = ra_i;
        srcb_s = RRSP;
        dste_s = RRSP;
      end
      POPQ: begin
        srca_s = RRSP;
        srcb_s = RRSP;
        dste_s = RRSP;
        dstm_s = ra_i;
      end
      default: begin
        srca_s = RNONE;
        srcb_s = RNONE;
        dste_s = RNONE;
        dstm_s = RNONE;
      end
    endcase
  end

  assign we_e_s = wb_en_i && (dste_s != RNONE);
  assign we_m_s = wb_en_i && (dstm_s != RNONE);

  regfile_2r2w u_regfile (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .we_e     (we_e_s),
    .addr_e   (dste_s),
    .data_e   (vale_i),
    .we_m     (we_m_s),
    .addr_m   (dstm_s),
    .data_m   (valm_i),
    .raddr_a  (srca_s),
    .rdata_a  (vala_o),
    .raddr_b  (srcb_s),
    .rdata_b  (valb_o),
    .dbg_addr (dbg_addr_i),
    .dbg_data (dbg_data_o)
  );

  // Commit counter: one tick per enabled instruction that writes a register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wb_cnt_r <= {CNT_W{1'b0}};
    end else if (we_e_s || we_m_s) begin
      wb_cnt_r <= wb_cnt_r + 32'd1;
    end else begin
      wb_cnt_r <= wb_cnt_r;
    end
  end

  assign srca_o   = srca_s;
  assign srcb_o   = srcb_s;
  assign dste_o   = dste_s;
  assign dstm_o   = dstm_s;
  assign wb_cnt_o = wb_cnt_r;

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback: a decode table checked against the
// reset register state, then hand-written commit sequences.
module tb_decode_writeback;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [3:0]  icode_i, ra_i, rb_i, dbg_addr_i;
  logic        cnd_i, wb_en_i;
  logic [63:0] vale_i, valm_i;
  logic [3:0]  srca_o, srcb_o, dste_o, dstm_o;
  logic [63:0] vala_o, valb_o, dbg_data_o;
  logic [31:0] wb_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  decode_writeback dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .icode_i(icode_i), .ra_i(ra_i), .rb_i(rb_i),
    .cnd_i(cnd_i), .vale_i(vale_i), .valm_i(valm_i), .wb_en_i(wb_en_i),
    .srca_o(srca_o), .srcb_o(srcb_o), .dste_o(dste_o), .dstm_o(dstm_o),
    .vala_o(vala_o), .valb_o(valb_o), .dbg_addr_i(dbg_addr_i),
    .dbg_data_o(dbg_data_o), .wb_cnt_o(wb_cnt_o)
  );

  typedef struct {
    logic [3:0]  icode, ra, rb;
    logic        cnd;
    logic [3:0]  srca, srcb, dste, dstm;
    logic [63:0] vala, valb;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] ve, input logic [63:0] vm,
                       input logic en);
    icode_i = ic; ra_i = a; rb_i = b; cnd_i = c; vale_i = ve; valm_i = vm; wb_en_i = en;
    #1;
  endtask

  task automatic dbg(input string name, input logic [3:0] addr, input logic [63:0] exp);
    dbg_addr_i = addr;
    #1;
    check(name, dbg_data_o, exp);
  endtask

  initial begin
    // icode ra rb cnd | srca srcb dste dstm | vala valb  (reset state: %rsp = 0x200)
    vecs[0]  = '{4'h0, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0};
    vecs[1]  = '{4'h1, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0};
    vecs[2]  = '{4'h2, 4'h3, 4'h1, 1'b1, 4'h3, 4'hF, 4'h1, 4'hF, 64'h0,   64'h0};
    vecs[3]  = '{4'h2, 4'h3, 4'h1, 1'b0, 4'h3, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0};
    vecs[4]  = '{4'h3, 4'hF, 4'h5, 1'b1, 4'hF, 4'hF, 4'h5, 4'hF, 64'h0,   64'h0};
    vecs[5]  = '{4'h4, 4'h1, 4'h4, 1'b1, 4'h1, 4'h4, 4'hF, 4'hF, 64'h0,   64'h200};
    vecs[6]  = '{4'h5, 4'h2, 4'h4, 1'b1, 4'hF, 4'h4, 4'hF, 4'h2, 64'h0,   64'h200};
    vecs[7]  = '{4'h6, 4'h4, 4'h7, 1'b1, 4'h4, 4'h7, 4'h7, 4'hF, 64'h200, 64'h0};
    vecs[8]  = '{4'h7, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0};
    vecs[9]  = '{4'h8, 4'h1, 4'h2, 1'b1, 4'hF, 4'h4, 4'h4, 4'hF, 64'h0,   64'h200};
    vecs[10] = '{4'h9, 4'h1, 4'h2, 1'b1, 4'h4, 4'h4, 4'h4, 4'hF, 64'h200, 64'h200};
    vecs[11] = '{4'hA, 4'h3, 4'hF, 1'b1, 4'h3, 4'h4, 4'h4, 4'hF, 64'h0,   64'h200};
    vecs[12] = '{4'hB, 4'h2, 4'hF, 1'b1, 4'h4, 4'h4, 4'h4, 4'h2, 64'h200, 64'h200};
    vecs[13] = '{4'hC, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0};
    vecs[14] = '{4'hF, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0};

    rst_n_i = 1'b0; dbg_addr_i = 4'h0;
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    step();
    rst_n_i = 1'b1;

    // Decode table against the reset register contents, commits disabled.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].icode, vecs[i].ra, vecs[i].rb, vecs[i].cnd, 64'h1234, 64'h5678, 1'b0);
      check($sformatf("v%0d_srca", i), 64'(srca_o), 64'(vecs[i].srca));
      check($sformatf("v%0d_srcb", i), 64'(srcb_o), 64'(vecs[i].srcb));
      check($sformatf("v%0d_dste", i), 64'(dste_o), 64'(vecs[i].dste));
      check($sformatf("v%0d_dstm", i), 64'(dstm_o), 64'(vecs[i].dstm));
      check($sformatf("v%0d_vala", i), vala_o, vecs[i].vala);
      check($sformatf("v%0d_valb", i), valb_o, vecs[i].valb);
      step();
    end
    check("reset_cnt", 64'(wb_cnt_o), 64'h0);
    dbg("reset_r0", 4'h0, 64'h0);
    dbg("reset_rsp", 4'h4, 64'h200);
    dbg("dbg_f", 4'hF, 64'h0);

    // irmovq $0x15, %rbx
    drive(4'h3, 4'hF, 4'h3, 1'b1, 64'h15, 64'h0, 1'b1);
    check("irmov_dste", 64'(dste_o), 64'h3);
    step();
    wb_en_i = 1'b0;
    dbg("irmov_r3", 4'h3, 64'h15);
    check("irmov_cnt", 64'(wb_cnt_o), 64'h1);

    // cmov not taken, then taken
    drive(4'h2, 4'h3, 4'h1, 1'b0, 64'h15, 64'h0, 1'b1);
    check("cmov_nt_dste", 64'(dste_o), 64'hF);
    step();
    wb_en_i = 1'b0;
    dbg("cmov_nt_r1", 4'h1, 64'h0);
    check("cmov_nt_cnt", 64'(wb_cnt_o), 64'h1);
    drive(4'h2, 4'h3, 4'h1, 1'b1, 64'h15, 64'h0, 1'b1);
    check("cmov_t_dste", 64'(dste_o), 64'h1);
    step();
    wb_en_i = 1'b0;
    dbg("cmov_t_r1", 4'h1, 64'h15);
    check("cmov_t_cnt", 64'(wb_cnt_o), 64'h2);

    // popq %rsp: M write wins over E write
    drive(4'hB, 4'h4, 4'hF, 1'b1, 64'h208, 64'hABCD, 1'b1);
    check("poprsp_dste", 64'(dste_o), 64'h4);
    check("poprsp_dstm", 64'(dstm_o), 64'h4);
    step();
    wb_en_i = 1'b0;
    dbg("poprsp_rsp", 4'h4, 64'hABCD);
    check("poprsp_cnt", 64'(wb_cnt_o), 64'h3);

    // popq %rdx: both ports write distinct registers
    drive(4'hB, 4'h2, 4'hF, 1'b1, 64'hABD5, 64'h99, 1'b1);
    step();
    wb_en_i = 1'b0;
    dbg("pop_rsp", 4'h4, 64'hABD5);
    dbg("pop_r2", 4'h2, 64'h99);
    check("pop_cnt", 64'(wb_cnt_o), 64'h4);

    // Disabled commit
    drive(4'h6, 4'h9, 4'h7, 1'b1, 64'h55, 64'h0, 1'b0);
    check("dis_srca", 64'(srca_o), 64'h9);
    check("dis_srcb", 64'(srcb_o), 64'h7);
    check("dis_dste", 64'(dste_o), 64'h7);
    step();
    dbg("dis_r7", 4'h7, 64'h0);
    check("dis_cnt", 64'(wb_cnt_o), 64'h4);

    // Read-before-write on the same register
    drive(4'h6, 4'h3, 4'h3, 1'b1, 64'h2A, 64'h0, 1'b1);
    check("rbw_vala", vala_o, 64'h15);
    check("rbw_valb", valb_o, 64'h15);
    step();
    wb_en_i = 1'b0;
    dbg("rbw_r3", 4'h3, 64'h2A);
    check("rbw_cnt", 64'(wb_cnt_o), 64'h5);

    // Enabled commit with no destination leaves the counter alone
    drive(4'h4, 4'h3, 4'h2, 1'b1, 64'h77, 64'h0, 1'b1);
    step();
    wb_en_i = 1'b0;
    check("nodst_cnt", 64'(wb_cnt_o), 64'h5);

    // Reset in the same cycle as a write
    drive(4'h3, 4'hF, 4'h5, 1'b1, 64'h77, 64'h0, 1'b1);
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    wb_en_i = 1'b0;
    dbg("rstw_r5", 4'h5, 64'h0);
    dbg("rstw_r3", 4'h3, 64'h0);
    dbg("rstw_rsp", 4'h4, 64'h200);
    check("rstw_cnt", 64'(wb_cnt_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
